// File: rtl/pc_update_sequencer.sv
// Multicycle PC-update controller: commits the next PC on each start pulse, either
// directly (seq/jump/branch/jr/rte) or through the EPC-save / vector-fetch exception path.
module pc_update_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op_class,
    input  logic       branch_taken,
    input  logic [2:0] excp_req,
    output logic [2:0] pc_src,
    output logic       pc_write,
    output logic       epc_write,
    output logic       mem_read,
    output logic [7:0] vec_addr,
    output logic [1:0] excp_code,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] SRC_REG_A    = 3'd0;
    localparam logic [2:0] SRC_ALU_RES  = 3'd1;
    localparam logic [2:0] SRC_JUMP     = 3'd2;
    localparam logic [2:0] SRC_ALU_OUT  = 3'd3;
    localparam logic [2:0] SRC_EPC      = 3'd4;
    localparam logic [2:0] SRC_EXC_CODE = 3'd5;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_EXC_EPC,
        S_EXC_RD,
        S_EXC_WAIT,
        S_EXC_LOAD,
        S_DONE
    } state_t;

    state_t     state_reg;
    logic [3:0] wait_cnt_reg;

    // Request decode, only meaningful in the cycle start is accepted.
    logic       illegal_op;
    logic       take_exc;
    logic [1:0] cause_next;
    logic [7:0] vec_next;
    logic [2:0] src_next;
    logic       write_next;

    always_comb begin
        illegal_op = (op_class > 3'd4);
        take_exc   = illegal_op || (excp_req != 3'b000);

        // Invalid opcode outranks overflow, which outranks divide-by-zero.
        cause_next = 2'd0;
        vec_next   = 8'h00;
        if (illegal_op || excp_req[1]) begin
            cause_next = 2'd1;
            vec_next   = 8'hFD;
        end else if (excp_req[0]) begin
            cause_next = 2'd2;
            vec_next   = 8'hFE;
        end else if (excp_req[2]) begin
            cause_next = 2'd3;
            vec_next   = 8'hFF;
        end

        src_next = SRC_ALU_RES;
        case (op_class)
            3'd0:    src_next = SRC_ALU_RES;
            3'd1:    src_next = SRC_JUMP;
            3'd2:    src_next = SRC_ALU_OUT;
            3'd3:    src_next = SRC_REG_A;
            3'd4:    src_next = SRC_EPC;
            default: src_next = SRC_ALU_RES;
        endcase

        write_next = !((op_class == 3'd2) && !branch_taken);
    end

    // Strobes are registered alongside the state so they line up with the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            pc_src       <= SRC_ALU_RES;
            vec_addr     <= 8'h00;
            excp_code    <= 2'd0;
            pc_write     <= 1'b0;
            epc_write    <= 1'b0;
            mem_read     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            mem_read  <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (take_exc) begin
                            excp_code <= cause_next;
                            vec_addr  <= vec_next;
                            epc_write <= 1'b1;
                            state_reg <= S_EXC_EPC;
                        end else begin
                            excp_code <= 2'd0;
                            pc_src    <= src_next;
                            pc_write  <= write_next;
                            state_reg <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_EXC_EPC: begin
                    mem_read  <= 1'b1;
                    state_reg <= S_EXC_RD;
                end
                S_EXC_RD: begin
                    mem_read     <= 1'b1;
                    wait_cnt_reg <= WAIT_LOAD;
                    state_reg    <= S_EXC_WAIT;
                end
                S_EXC_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        pc_src    <= SRC_EXC_CODE;
                        pc_write  <= 1'b1;
                        state_reg <= S_EXC_LOAD;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        mem_read     <= 1'b1;
                    end
                end
                S_EXC_LOAD: begin
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
